regfile_write_scheduler: RTL and testbench
==========================================

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: issue_valid  input  1  decode stage presents an instruction.
REQ-004 SHALL have: issue_rs, issue_rt  input  5 each  source register numbers.
REQ-005 SHALL have: issue_uses_rt  input  1  instruction reads rt.
REQ-006 SHALL have: issue_wr, issue_rd  input  1, 5  instruction will write rd.
REQ-007 SHALL have: stall  output  1  issue blocked this cycle.
REQ-008 SHALL have: alu_wb_valid, alu_wb_reg, alu_wb_data  input  1, 5, 32  pipelined writeback, cannot stall.
REQ-009 SHALL have: md_wb_valid, md_wb_reg, md_wb_data  input  1, 5, 32  multi-cycle mul/div writeback.
REQ-010 SHALL have: md_wb_ready  output  1  md writeback accepted this cycle.
REQ-011 SHALL have: regwrite, writebackreg, data_towrite_memwb  output  1, 5, 32  drives register-file write port.
REQ-012 SHALL have: pending  output  32  scoreboard bitmap; sb_err  output  1  sticky protocol error.

Function
REQ-013 Scoreboard pending[31:0]; bit r SHALL mean a write to register r is in flight.
REQ-014 stall SHALL be combinational: issue_valid & (pending[rs] | (issue_uses_rt & pending[rt]) | (issue_wr & pending[rd])).
REQ-015 Issue accepted when issue_valid & !stall; if issue_wr & rd!=0, pending[rd] SHALL set at that edge.
REQ-016 Register 0 SHALL never be marked pending; writebacks to register 0 SHALL be dropped (regwrite stays 0).
REQ-017 Arbitration: alu_wb_valid SHALL win; md_wb_ready = !alu_wb_valid (combinational); md handshake completes when md_wb_valid & md_wb_ready.
REQ-018 md requester SHALL hold valid/reg/data stable until accepted; scheduler SHALL NOT buffer a refused md request.
REQ-019 Winning writeback SHALL appear on regwrite/writebackreg/data_towrite_memwb registered, latency 1 cycle, one write per cycle maximum.
REQ-020 pending[writebackreg] SHALL clear on the edge where registered regwrite is 1 (the edge the register file commits), so a dependent issue reads the new value the cycle after.
REQ-021 Simultaneous set and clear of the same bit SHALL resolve to set.
REQ-022 sb_err SHALL set (sticky until reset) when a writeback to register r!=0 wins while pending[r]=0.
REQ-023 No writeback in a cycle: regwrite=0, writebackreg and data_towrite_memwb hold previous values.

Reset
REQ-024 rst SHALL clear pending, regwrite, writebackreg, data_towrite_memwb, sb_err to 0 at the next edge.
REQ-025 While rst=1: no issue accepted, md_wb_ready=0, stall=0, inputs ignored; in-flight md requests are lost and must be re-presented.

Configuration
REQ-026 Macro REGFILE_SCHED_STATS_EN: when defined, SHALL add output stall_cycles [31:0] counting cycles with stall=1, reset to 0, saturating at 0xFFFFFFFF; when undefined, port and counter SHALL be absent, all other behaviour identical.

Structure
REQ-027 Package regsched_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 and enum wb_src_t {WB_NONE, WB_ALU, WB_MD}.
REQ-028 Arbitration and output register SHALL live in sub-module wb_port_arbiter; scoreboard, stall logic and stats stay in the top.

Verification
REQ-029 Issue rd=5 at cycle 0, rs=5 at cycle 1 -> stall=1 until ALU writeback of reg 5 commits; stall=0 the cycle after regwrite=1 edge.
REQ-030 alu_wb (reg 3, 0x11) and md_wb (reg 4, 0x22) same cycle -> reg 3 written next cycle, md_wb_ready=0, reg 4 written one cycle later.
REQ-031 Issue rd=0 then alu_wb reg 0 data 0xFF -> pending stays 0, regwrite never 1, sb_err=0.
REQ-032 alu_wb reg 7 with pending[7]=0 -> write occurs, sb_err=1 and stays 1 until rst.
REQ-033 rst asserted with pending=0x0000_0120 and md_wb_valid=1 -> next cycle pending=0, regwrite=0, md_wb_ready=0.
REQ-034 With REGFILE_SCHED_STATS_EN, 3-cycle RAW stall -> stall_cycles increments by exactly 3.

Source files
------------

// File: rtl/regsched_pkg.sv
// Shared widths, writeback source encoding and a register-number decoder
// for the register-file write scheduler.
package regsched_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MD
    } wb_src_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Picks one writeback per cycle (ALU has priority over mul/div) and registers
// it onto the register-file write port.
module wb_port_arbiter
    import regsched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wb_valid,
    input  logic [REG_ADDR_W-1:0] alu_wb_reg,
    input  logic [DATA_W-1:0]     alu_wb_data,
    input  logic                  md_wb_valid,
    input  logic [REG_ADDR_W-1:0] md_wb_reg,
    input  logic [DATA_W-1:0]     md_wb_data,
    output logic                  md_wb_ready,
    output logic                  win_valid,
    output logic [REG_ADDR_W-1:0] win_reg,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] writebackreg,
    output logic [DATA_W-1:0]     data_towrite_memwb
);

    wb_src_t           src;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        md_wb_ready = !rst && !alu_wb_valid;
        src         = WB_NONE;
        if (!rst) begin
            if (alu_wb_valid)
                src = WB_ALU;
            else if (md_wb_valid)
                src = WB_MD;
        end
        win_reg  = '0;
        win_data = '0;
        case (src)
            WB_ALU: begin
                win_reg  = alu_wb_reg;
                win_data = alu_wb_data;
            end
            WB_MD: begin
                win_reg  = md_wb_reg;
                win_data = md_wb_data;
            end
            default: ;
        endcase
        // Register 0 is hardwired: a winning write to it is simply dropped.
        win_valid = (src != WB_NONE) && (win_reg != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite           <= 1'b0;
            writebackreg       <= '0;
            data_towrite_memwb <= '0;
        end else begin
            regwrite <= win_valid;
            if (win_valid) begin
                writebackreg       <= win_reg;
                data_towrite_memwb <= win_data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Scoreboarded register-file write scheduler: RAW/WAW issue stall plus a
// single arbitrated write port. Optional stall counter: REGFILE_SCHED_STATS_EN.
module regfile_write_scheduler
    import regsched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_uses_rt,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  stall,
    input  logic                  alu_wb_valid,
    input  logic [REG_ADDR_W-1:0] alu_wb_reg,
    input  logic [DATA_W-1:0]     alu_wb_data,
    input  logic                  md_wb_valid,
    input  logic [REG_ADDR_W-1:0] md_wb_reg,
    input  logic [DATA_W-1:0]     md_wb_data,
    output logic                  md_wb_ready,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] writebackreg,
    output logic [DATA_W-1:0]     data_towrite_memwb,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  sb_err
`ifdef REGFILE_SCHED_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    logic                  win_valid;
    logic [REG_ADDR_W-1:0] win_reg;
    logic                  issue_fire;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;

    wb_port_arbiter u_arb (
        .clk                (clk),
        .rst                (rst),
        .alu_wb_valid       (alu_wb_valid),
        .alu_wb_reg         (alu_wb_reg),
        .alu_wb_data        (alu_wb_data),
        .md_wb_valid        (md_wb_valid),
        .md_wb_reg          (md_wb_reg),
        .md_wb_data         (md_wb_data),
        .md_wb_ready        (md_wb_ready),
        .win_valid          (win_valid),
        .win_reg            (win_reg),
        .regwrite           (regwrite),
        .writebackreg       (writebackreg),
        .data_towrite_memwb (data_towrite_memwb)
    );

    always_comb begin
        stall = !rst && issue_valid &&
                (pending[issue_rs] ||
                 (issue_uses_rt && pending[issue_rt]) ||
                 (issue_wr && pending[issue_rd]));
        issue_fire = !rst && issue_valid && !stall;
        set_mask   = (issue_fire && issue_wr && (issue_rd != '0)) ? reg_onehot(issue_rd) : '0;
        // Free the register on the same edge the register file commits it.
        clr_mask   = regwrite ? reg_onehot(writebackreg) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (win_valid && !pending[win_reg])
                sb_err <= 1'b1;
        end
    end

`ifdef REGFILE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: stall vector table,
// directed corner sequences and randomized traffic against a reference model.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_uses_rt, issue_wr;
    logic        stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic        md_wb_valid;
    logic [4:0]  md_wb_reg;
    logic [31:0] md_wb_data;
    logic        md_wb_ready;
    logic        regwrite;
    logic [4:0]  writebackreg;
    logic [31:0] data_towrite_memwb;
    logic [31:0] pending;
    logic        sb_err;
`ifdef REGFILE_SCHED_STATS_EN
    logic [31:0] stall_cycles;
`endif

    regfile_write_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .issue_valid        (issue_valid),
        .issue_rs           (issue_rs),
        .issue_rt           (issue_rt),
        .issue_uses_rt      (issue_uses_rt),
        .issue_wr           (issue_wr),
        .issue_rd           (issue_rd),
        .stall              (stall),
        .alu_wb_valid       (alu_wb_valid),
        .alu_wb_reg         (alu_wb_reg),
        .alu_wb_data        (alu_wb_data),
        .md_wb_valid        (md_wb_valid),
        .md_wb_reg          (md_wb_reg),
        .md_wb_data         (md_wb_data),
        .md_wb_ready        (md_wb_ready),
        .regwrite           (regwrite),
        .writebackreg       (writebackreg),
        .data_towrite_memwb (data_towrite_memwb),
        .pending            (pending),
        .sb_err             (sb_err)
`ifdef REGFILE_SCHED_STATS_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: which registers have an outstanding write, and what the
    // register-file port showed after the last edge.
    bit          busy [32];
    bit          m_rw;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_sb;
    longint      m_stalls;

    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       uses_rt;
        bit       wr;
        bit [4:0] rd;
        bit       exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = busy[i];
        return v;
    endfunction

    function automatic logic [4:0] pick_reg();
        int q[$];
        for (int i = 1; i < 32; i++) if (busy[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 7) != 0)
            return 5'(q[$urandom_range(0, q.size() - 1)]);
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic set_idle();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_uses_rt = 0;
        issue_wr = 0; issue_rd = 0;
        alu_wb_valid = 0; alu_wb_reg = 0; alu_wb_data = 0;
        md_wb_valid = 0; md_wb_reg = 0; md_wb_data = 0;
    endtask

    task automatic set_issue(input bit [4:0] rs, input bit [4:0] rt, input bit urt,
                             input bit wr, input bit [4:0] rd);
        issue_valid = 1; issue_rs = rs; issue_rt = rt; issue_uses_rt = urt;
        issue_wr = wr; issue_rd = rd;
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic tick();
        bit          exp_stall, exp_ready, fire, win, hit;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        #1;
        exp_stall = !rst && issue_valid &&
                    (busy[issue_rs] || (issue_uses_rt && busy[issue_rt]) || (issue_wr && busy[issue_rd]));
        exp_ready = !rst && !alu_wb_valid;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("md_wb_ready", {31'b0, md_wb_ready}, {31'b0, exp_ready});
        fire  = issue_valid && !exp_stall;
        win   = alu_wb_valid || md_wb_valid;
        wreg  = alu_wb_valid ? alu_wb_reg : md_wb_reg;
        wdata = alu_wb_valid ? alu_wb_data : md_wb_data;
        @(posedge clk);
        if (rst) begin
            foreach (busy[i]) busy[i] = 0;
            m_rw = 0; m_reg = 0; m_data = 0; m_sb = 0; m_stalls = 0;
        end else begin
            hit = win && (wreg != 0) && !busy[wreg];
            if (hit) m_sb = 1;
            if (m_rw) busy[m_reg] = 0;
            if (fire && issue_wr && issue_rd != 0) busy[issue_rd] = 1;
            m_rw = win && (wreg != 0);
            if (m_rw) begin
                m_reg  = wreg;
                m_data = wdata;
            end
            if (exp_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        end
        #1;
        chk("regwrite", {31'b0, regwrite}, {31'b0, m_rw});
        chk("writebackreg", {27'b0, writebackreg}, {27'b0, m_reg});
        chk("data_towrite_memwb", data_towrite_memwb, m_data);
        chk("pending", pending, busy_vec());
        chk("sb_err", {31'b0, sb_err}, {31'b0, m_sb});
`ifdef REGFILE_SCHED_STATS_EN
        chk("stall_cycles", stall_cycles, 32'(m_stalls));
`endif
    endtask

    vec_t vecs[9];
`ifdef REGFILE_SCHED_STATS_EN
    logic [31:0] cnt0;
`endif

    initial begin
        vecs[0] = '{1, 1, 2, 1, 1, 3, 0};
        vecs[1] = '{1, 5, 0, 0, 0, 0, 1};
        vecs[2] = '{1, 1, 9, 1, 0, 0, 1};
        vecs[3] = '{1, 1, 9, 0, 0, 0, 0};
        vecs[4] = '{1, 1, 2, 0, 1, 9, 1};
        vecs[5] = '{1, 1, 2, 1, 0, 9, 0};
        vecs[6] = '{1, 0, 0, 1, 1, 0, 0};
        vecs[7] = '{1, 9, 5, 1, 1, 5, 1};
        vecs[8] = '{0, 5, 9, 1, 1, 9, 0};

        foreach (busy[i]) busy[i] = 0;
        m_rw = 0; m_reg = 0; m_data = 0; m_sb = 0; m_stalls = 0;
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // RAW on r5 held until the ALU writeback commits.
        set_issue(0, 0, 0, 1, 5);
        tick();
        chk("raw_pending5", pending, 32'h0000_0020);
        set_issue(5, 0, 0, 0, 0);
`ifdef REGFILE_SCHED_STATS_EN
        cnt0 = stall_cycles;
`endif
        tick();
        alu_wb_valid = 1; alu_wb_reg = 5; alu_wb_data = 32'hABCD;
        tick();
        alu_wb_valid = 0;
        #1 chk("raw_stall_hold", {31'b0, stall}, 32'd1);
        tick();
        chk("raw_pending_clear", pending, 32'd0);
        #1 chk("raw_stall_clear", {31'b0, stall}, 32'd0);
        tick();
`ifdef REGFILE_SCHED_STATS_EN
        chk("stats_delta3", stall_cycles - cnt0, 32'd3);
`endif

        // ALU and MD collide: ALU first, MD held and written one cycle later.
        set_issue(0, 0, 0, 1, 3);
        tick();
        set_issue(0, 0, 0, 1, 4);
        tick();
        set_idle();
        alu_wb_valid = 1; alu_wb_reg = 3; alu_wb_data = 32'h11;
        md_wb_valid = 1; md_wb_reg = 4; md_wb_data = 32'h22;
        #1 chk("arb_md_refused", {31'b0, md_wb_ready}, 32'd0);
        tick();
        chk("arb_alu_reg", {27'b0, writebackreg}, 32'd3);
        chk("arb_alu_data", data_towrite_memwb, 32'h11);
        alu_wb_valid = 0;
        tick();
        chk("arb_md_we", {31'b0, regwrite}, 32'd1);
        chk("arb_md_reg", {27'b0, writebackreg}, 32'd4);
        chk("arb_md_data", data_towrite_memwb, 32'h22);
        md_wb_valid = 0;
        tick();
        chk("arb_pending_clear", pending, 32'd0);

        // Register 0 is never pending and never written.
        set_issue(0, 0, 0, 1, 0);
        tick();
        chk("r0_pending", pending, 32'd0);
        set_idle();
        alu_wb_valid = 1; alu_wb_reg = 0; alu_wb_data = 32'hFF;
        tick();
        chk("r0_no_write", {31'b0, regwrite}, 32'd0);
        alu_wb_valid = 0;
        tick();
        chk("r0_sb_err", {31'b0, sb_err}, 32'd0);

        // Unexpected writeback flags a sticky error that only reset clears.
        alu_wb_valid = 1; alu_wb_reg = 7; alu_wb_data = 32'h77;
        tick();
        chk("err_write", {31'b0, regwrite}, 32'd1);
        chk("err_set", {31'b0, sb_err}, 32'd1);
        alu_wb_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", {31'b0, sb_err}, 32'd1);
        rst = 1;
        tick();
        chk("err_reset", {31'b0, sb_err}, 32'd0);
        rst = 0;

        // Reset while work is in flight.
        set_issue(0, 0, 0, 1, 5);
        tick();
        set_issue(0, 0, 0, 1, 8);
        tick();
        chk("rst_pre_pending", pending, 32'h0000_0120);
        set_idle();
        md_wb_valid = 1; md_wb_reg = 5; md_wb_data = 32'h55;
        rst = 1;
        #1 chk("rst_md_ready", {31'b0, md_wb_ready}, 32'd0);
        tick();
        chk("rst_pending", pending, 32'd0);
        chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
        chk("rst_md_ready_after", {31'b0, md_wb_ready}, 32'd0);
        rst = 0;
        md_wb_valid = 0;
        tick();

        // Stall decode table with r5 and r9 outstanding.
        set_issue(0, 0, 0, 1, 5);
        tick();
        set_issue(0, 0, 0, 1, 9);
        tick();
        set_idle();
        tick();
        foreach (vecs[i]) begin
            @(negedge clk);
            issue_valid = vecs[i].valid; issue_rs = vecs[i].rs; issue_rt = vecs[i].rt;
            issue_uses_rt = vecs[i].uses_rt; issue_wr = vecs[i].wr; issue_rd = vecs[i].rd;
            #1 chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            #1 issue_valid = 0;
        end
        set_idle();

        // Randomized traffic; the MD requester holds its request until accepted.
        for (int n = 0; n < 400; n++) begin
            bit md_acc;
            rst = ($urandom_range(0, 79) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_rs = pick_reg(); issue_rt = pick_reg(); issue_rd = pick_reg();
            issue_uses_rt = $urandom_range(0, 1); issue_wr = $urandom_range(0, 1);
            alu_wb_valid = ($urandom_range(0, 2) == 0);
            alu_wb_reg = pick_reg(); alu_wb_data = $urandom;
            if (!md_wb_valid && $urandom_range(0, 3) == 0) begin
                md_wb_valid = 1; md_wb_reg = pick_reg(); md_wb_data = $urandom;
            end
            md_acc = md_wb_valid && !alu_wb_valid && !rst;
            tick();
            if (md_acc) md_wb_valid = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
